umi_regif_buf: RTL and testbench

Buffered, parametrised UMI-to-register bridge. It converts UMI requests into single-cycle register strobes and queues responses in a DEPTH-entry FIFO. Requests are accepted every cycle while response space exists, and back-pressure on the response channel never drops or corrupts data. Optional single-cycle atomics are supported. It sits between a UMI device port and a block's control/status register file.

---
 rtl/umi_regif_buf.sv | 248 ++++++++++++++++++++++++
 tb/tb_umi_regif_buf.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/umi_regif_buf.sv
// -----------------------------------------------------------------------------
// umi_regif_buf
// Buffered UMI-to-register bridge. Each accepted UMI request becomes a
// single-cycle register strobe, and its response is queued in a DEPTH-entry
// FIFO so that back-pressure on the response channel never loses data.
//
// Optional feature macro: UMI_REGIF_ATOMIC_EN (enables single-cycle atomics).
//
// Ports:
//   clk, nreset                      clock, async active-low reset
//   udev_req_*                       UMI request channel (in)
//   udev_resp_*                      UMI response channel (out), FIFO head
//   reg_addr/read/write              register access strobes (combinational)
//   reg_size/len/atype               request command fields
//   reg_wrdata                       write data (atomic result for atomics)
//   reg_rddata                       combinational read data from register file
// -----------------------------------------------------------------------------
module umi_regif_buf #(
  parameter int AW        = 64,
  parameter int CW        = 32,
  parameter int DW        = 256,
  parameter int RW        = 64,
  parameter int GRPOFFSET = 24,
  parameter int GRPAW     = 4,
  parameter int GRPID     = 0,
  parameter int DEPTH     = 4
) (
  input  logic          clk,
  input  logic          nreset,
  // request channel
  input  logic          udev_req_valid,
  output logic          udev_req_ready,
  input  logic [CW-1:0] udev_req_cmd,
  input  logic [AW-1:0] udev_req_dstaddr,
  input  logic [AW-1:0] udev_req_srcaddr,
  input  logic [DW-1:0] udev_req_data,
  // response channel
  output logic          udev_resp_valid,
  input  logic          udev_resp_ready,
  output logic [CW-1:0] udev_resp_cmd,
  output logic [AW-1:0] udev_resp_dstaddr,
  output logic [AW-1:0] udev_resp_srcaddr,
  output logic [DW-1:0] udev_resp_data,
  // register interface
  output logic [AW-1:0] reg_addr,
  output logic          reg_read,
  output logic          reg_write,
  output logic [2:0]    reg_size,
  output logic [7:0]    reg_len,
  output logic [7:0]    reg_atype,
  output logic [RW-1:0] reg_wrdata,
  input  logic [RW-1:0] reg_rddata
);

  localparam int unsigned PW    = $clog2(DEPTH);
  localparam int unsigned NCOPY = DW / RW;
  localparam int unsigned RBYTE = RW / 8;

  localparam logic [4:0] REQ_READ    = 5'h01;
  localparam logic [4:0] REQ_WRITE   = 5'h03;
  localparam logic [4:0] REQ_POSTED  = 5'h05;
  localparam logic [4:0] REQ_ATOMIC  = 5'h09;
  localparam logic [4:0] RESP_READ   = 5'h02;
  localparam logic [4:0] RESP_WRITE  = 5'h04;

  localparam logic [1:0] ERR_OK  = 2'b00;
  localparam logic [1:0] ERR_SLV = 2'b10;
  localparam logic [1:0] ERR_DEC = 2'b11;

  // FIFO state
  logic [PW:0]   r_count;
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_cmd  [DEPTH];
  logic [AW-1:0] r_dst  [DEPTH];
  logic [AW-1:0] r_src  [DEPTH];
  logic [RW-1:0] r_data [DEPTH];

  logic          w_accept;
  logic          w_pop;
  logic          w_push;
  logic [4:0]    w_opcode;
  logic [2:0]    w_size;
  logic [7:0]    w_len;
  logic [7:0]    w_eff_len;
  logic [16:0]   w_need;
  logic          w_hit;
  logic          w_fits;
  logic          w_rd;
  logic          w_wr;
  logic [4:0]    w_resp_op;
  logic [1:0]    w_err;
  logic [RW-1:0] w_push_data;
  logic [CW-1:0] w_resp_cmd;
  logic [RW-1:0] w_op_b;
  logic          w_amo_ok;
  logic [RW-1:0] w_amo_res;

  assign w_accept = udev_req_valid & udev_req_ready;
  assign w_pop    = udev_resp_valid & udev_resp_ready;

  assign udev_req_ready  = (r_count != (PW+1)'(DEPTH));
  assign udev_resp_valid = (r_count != '0);

  assign w_opcode = udev_req_cmd[4:0];
  assign w_size   = udev_req_cmd[7:5];
  assign w_len    = udev_req_cmd[15:8];
  assign w_op_b   = udev_req_data[RW-1:0];

  assign w_hit = (udev_req_dstaddr[GRPOFFSET +: GRPAW] == GRPAW'(GRPID));

  // Atomics carry atype in the len field and always touch a single word.
  assign w_eff_len = (w_opcode == REQ_ATOMIC) ? 8'd0 : w_len;
  assign w_need    = 17'((17'(w_eff_len) + 17'd1) << w_size);
  assign w_fits    = (w_need <= 17'(RBYTE));

`ifdef UMI_REGIF_ATOMIC_EN
  // Atomic ALU; signed comparisons are at full register width.
  always_comb begin
    w_amo_ok  = 1'b1;
    w_amo_res = w_op_b;
    case (w_len)
      8'h00: w_amo_res = reg_rddata + w_op_b;
      8'h01: w_amo_res = reg_rddata & w_op_b;
      8'h02: w_amo_res = reg_rddata | w_op_b;
      8'h03: w_amo_res = reg_rddata ^ w_op_b;
      8'h04: w_amo_res = ($signed(reg_rddata) > $signed(w_op_b)) ? reg_rddata : w_op_b;
      8'h05: w_amo_res = ($signed(reg_rddata) < $signed(w_op_b)) ? reg_rddata : w_op_b;
      8'h06: w_amo_res = (reg_rddata > w_op_b) ? reg_rddata : w_op_b;
      8'h07: w_amo_res = (reg_rddata < w_op_b) ? reg_rddata : w_op_b;
      8'h08: w_amo_res = w_op_b;
      default: w_amo_ok = 1'b0;
    endcase
  end
  assign reg_wrdata = (w_opcode == REQ_ATOMIC) ? w_amo_res : w_op_b;
`else
  assign w_amo_ok   = 1'b0;
  assign w_amo_res  = w_op_b;
  assign reg_wrdata = w_op_b;
`endif

  // Request decode: strobes and response to push for the accepted request.
  always_comb begin
    w_rd        = 1'b0;
    w_wr        = 1'b0;
    w_push      = 1'b0;
    w_resp_op   = RESP_WRITE;
    w_err       = ERR_OK;
    w_push_data = '0;
    // Response-class (and invalid) commands have opcode[0]=0 and are dropped.
    if (w_accept && w_opcode[0]) begin
      case (w_opcode)
        REQ_READ: begin
          w_push    = 1'b1;
          w_resp_op = RESP_READ;
          if (!w_hit)       w_err = ERR_DEC;
          else if (!w_fits) w_err = ERR_SLV;
          else begin
            w_rd        = 1'b1;
            w_push_data = reg_rddata;
          end
        end
        REQ_WRITE: begin
          w_push = 1'b1;
          if (!w_hit)       w_err = ERR_DEC;
          else if (!w_fits) w_err = ERR_SLV;
          else              w_wr  = 1'b1;
        end
        REQ_POSTED: begin
          // Misses are silently dropped; an oversized hit still reports SLVERR.
          if (w_hit && w_fits) w_wr = 1'b1;
          else if (w_hit) begin
            w_push = 1'b1;
            w_err  = ERR_SLV;
          end
        end
        REQ_ATOMIC: begin
          w_push    = 1'b1;
          w_resp_op = RESP_READ;
          if (!w_hit) w_err = ERR_DEC;
          else if (w_fits && w_amo_ok) begin
            w_rd        = 1'b1;
            w_wr        = 1'b1;
            w_push_data = reg_rddata;
          end
          else w_err = ERR_SLV;
        end
        default: begin
          w_push = 1'b1;
          w_err  = ERR_SLV;
        end
      endcase
    end
  end

  // Response command: request command with opcode and err fields replaced.
  always_comb begin
    w_resp_cmd        = udev_req_cmd;
    w_resp_cmd[4:0]   = w_resp_op;
    w_resp_cmd[26:25] = w_err;
  end

  assign reg_addr  = udev_req_dstaddr;
  assign reg_read  = w_rd;
  assign reg_write = w_wr;
  assign reg_size  = w_size;
  assign reg_len   = w_len;
  assign reg_atype = w_len;

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_count  <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end
    else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      if (w_push && !w_pop)      r_count <= r_count + (PW+1)'(1);
      else if (w_pop && !w_push) r_count <= r_count - (PW+1)'(1);
    end
  end

  // FIFO storage; cleared on reset so the idle response channel reads zero.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_cmd[i]  <= '0;
        r_dst[i]  <= '0;
        r_src[i]  <= '0;
        r_data[i] <= '0;
      end
    end
    else if (w_push) begin
      r_cmd[r_wr_ptr]  <= w_resp_cmd;
      r_dst[r_wr_ptr]  <= udev_req_srcaddr;
      r_src[r_wr_ptr]  <= udev_req_dstaddr;
      r_data[r_wr_ptr] <= w_push_data;
    end
  end

  assign udev_resp_cmd     = r_cmd[r_rd_ptr];
  assign udev_resp_dstaddr = r_dst[r_rd_ptr];
  assign udev_resp_srcaddr = r_src[r_rd_ptr];
  assign udev_resp_data    = {NCOPY{r_data[r_rd_ptr]}};

endmodule

// File: tb/tb_umi_regif_buf.sv
// -----------------------------------------------------------------------------
// tb_umi_regif_buf
// Directed self-checking bench for umi_regif_buf with default parameters.
// Inputs change 1 time unit after the rising edge; outputs are sampled 1 unit
// later, well away from the next rising edge.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_umi_regif_buf;

  localparam int AW = 64;
  localparam int CW = 32;
  localparam int DW = 256;
  localparam int RW = 64;

  localparam logic [4:0] OP_READ   = 5'h01;
  localparam logic [4:0] OP_WRITE  = 5'h03;
  localparam logic [4:0] OP_POSTED = 5'h05;
  localparam logic [4:0] OP_ATOMIC = 5'h09;
  localparam logic [4:0] OP_RRESP  = 5'h02;
  localparam logic [4:0] OP_WRESP  = 5'h04;

  // Fixed non-zero command side fields so their copy into responses is visible.
  localparam logic [4:0] HOST = 5'h13;
  localparam logic [1:0] USER = 2'b01;
  localparam logic       EX   = 1'b0;
  localparam logic       EOF  = 1'b1;
  localparam logic       EOM  = 1'b1;
  localparam logic [1:0] PROT = 2'b10;
  localparam logic [3:0] QOS  = 4'h5;

  logic          clk = 1'b0;
  logic          nreset = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [CW-1:0] req_cmd = '0;
  logic [AW-1:0] req_dst = '0;
  logic [AW-1:0] req_src = '0;
  logic [DW-1:0] req_data = '0;
  logic          resp_valid;
  logic          resp_ready = 1'b0;
  logic [CW-1:0] resp_cmd;
  logic [AW-1:0] resp_dst;
  logic [AW-1:0] resp_src;
  logic [DW-1:0] resp_data;
  logic [AW-1:0] reg_addr;
  logic          reg_read;
  logic          reg_write;
  logic [2:0]    reg_size;
  logic [7:0]    reg_len;
  logic [7:0]    reg_atype;
  logic [RW-1:0] reg_wrdata;
  logic [RW-1:0] reg_rddata = '0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  umi_regif_buf dut (
    .clk               (clk),
    .nreset            (nreset),
    .udev_req_valid    (req_valid),
    .udev_req_ready    (req_ready),
    .udev_req_cmd      (req_cmd),
    .udev_req_dstaddr  (req_dst),
    .udev_req_srcaddr  (req_src),
    .udev_req_data     (req_data),
    .udev_resp_valid   (resp_valid),
    .udev_resp_ready   (resp_ready),
    .udev_resp_cmd     (resp_cmd),
    .udev_resp_dstaddr (resp_dst),
    .udev_resp_srcaddr (resp_src),
    .udev_resp_data    (resp_data),
    .reg_addr          (reg_addr),
    .reg_read          (reg_read),
    .reg_write         (reg_write),
    .reg_size          (reg_size),
    .reg_len           (reg_len),
    .reg_atype         (reg_atype),
    .reg_wrdata        (reg_wrdata),
    .reg_rddata        (reg_rddata)
  );

  function automatic logic [CW-1:0] mk_cmd(input logic [4:0] op, input logic [2:0] sz,
                                           input logic [7:0] ln, input logic [1:0] u);
    return {HOST, u, EX, EOF, EOM, PROT, QOS, ln, sz, op};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_req();
    req_valid = 1'b0;
    req_cmd   = '0;
  endtask

  task automatic test_reset();
    nreset = 1'b0;
    #2;
    checks++;
    if (resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid got %b want 0", resp_valid); end
    checks++;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready got %b want 1", req_ready); end
    checks++;
    if (resp_cmd !== '0 || resp_data !== '0 || resp_dst !== '0) begin
      errors++; $display("FAIL reset_resp_fields got cmd=%h dst=%h want 0", resp_cmd, resp_dst);
    end
    checks++;
    if (reg_read !== 1'b0 || reg_write !== 1'b0) begin
      errors++; $display("FAIL reset_strobes got r=%b w=%b want 0", reg_read, reg_write);
    end
    @(negedge clk);
    nreset = 1'b1;
    tick();
  endtask

  task automatic test_read_hit();
    logic [RW-1:0] rd;
    rd = 64'h1122334455667788;
    resp_ready = 1'b1;
    reg_rddata = rd;
    req_valid  = 1'b1;
    req_cmd    = mk_cmd(OP_READ, 3'd3, 8'd0, USER);
    req_dst    = 64'h0000_0000_0000_1000;
    req_src    = 64'hAAAA_0000_0000_0040;
    #1;
    checks++;
    if (reg_read !== 1'b1 || reg_write !== 1'b0) begin
      errors++; $display("FAIL read_strobe got r=%b w=%b want r=1 w=0", reg_read, reg_write);
    end
    checks++;
    if (reg_addr !== 64'h1000 || reg_size !== 3'd3 || reg_len !== 8'd0) begin
      errors++; $display("FAIL read_fields got addr=%h size=%0d len=%0d", reg_addr, reg_size, reg_len);
    end
    tick();
    idle_req();
    #1;
    checks++;
    if (reg_read !== 1'b0) begin errors++; $display("FAIL read_pulse_len got %b want 0", reg_read); end
    checks++;
    if (resp_valid !== 1'b1 || resp_cmd !== mk_cmd(OP_RRESP, 3'd3, 8'd0, 2'b00)) begin
      errors++; $display("FAIL read_resp_cmd got v=%b cmd=%h want v=1 cmd=%h", resp_valid, resp_cmd,
                         mk_cmd(OP_RRESP, 3'd3, 8'd0, 2'b00));
    end
    checks++;
    if (resp_dst !== 64'hAAAA_0000_0000_0040 || resp_src !== 64'h1000) begin
      errors++; $display("FAIL read_resp_addr got dst=%h src=%h", resp_dst, resp_src);
    end
    checks++;
    if (resp_data !== {4{rd}}) begin errors++; $display("FAIL read_resp_data got %h want %h", resp_data, {4{rd}}); end
    tick();
    checks++;
    if (resp_valid !== 1'b0) begin errors++; $display("FAIL read_resp_pop got %b want 0", resp_valid); end
  endtask

  task automatic test_back_to_back();
    resp_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      req_valid = 1'b1;
      req_cmd   = mk_cmd(OP_WRITE, 3'd2, 8'd0, USER);
      req_dst   = 64'h2000 + 64'(i * 8);
      req_src   = 64'h5000 + 64'(i);
      req_data  = DW'(64'hC0DE_0000 + 64'(i));
      #1;
      checks++;
      if (req_ready !== 1'b1 || reg_write !== 1'b1 || reg_wrdata !== 64'hC0DE_0000 + 64'(i)) begin
        errors++; $display("FAIL b2b_accept_%0d got rdy=%b w=%b wd=%h", i, req_ready, reg_write, reg_wrdata);
      end
      tick();
    end
    // Full: a valid request is not accepted and produces no strobe.
    #1;
    checks++;
    if (req_ready !== 1'b0 || reg_write !== 1'b0) begin
      errors++; $display("FAIL b2b_full got rdy=%b w=%b want rdy=0 w=0", req_ready, reg_write);
    end
    idle_req();
    resp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if (resp_valid !== 1'b1 || resp_dst !== 64'h5000 + 64'(i) ||
          resp_cmd !== mk_cmd(OP_WRESP, 3'd2, 8'd0, 2'b00)) begin
        errors++; $display("FAIL b2b_resp_%0d got v=%b dst=%h cmd=%h", i, resp_valid, resp_dst, resp_cmd);
      end
      checks++;
      if (req_ready !== (i != 0)) begin
        errors++; $display("FAIL b2b_ready_%0d got %b want %b", i, req_ready, (i != 0));
      end
      tick();
    end
    checks++;
    if (resp_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain got %b want 0", resp_valid); end
  endtask

  task automatic test_posted_and_miss();
    resp_ready = 1'b1;
    req_valid  = 1'b1;
    req_cmd    = mk_cmd(OP_POSTED, 3'd3, 8'd0, USER);
    req_dst    = 64'h0000_0000_00FF_0010;
    req_data   = DW'(64'h77);
    #1;
    checks++;
    if (reg_write !== 1'b1) begin errors++; $display("FAIL posted_hit_strobe got %b want 1", reg_write); end
    tick();
    idle_req();
    #1;
    checks++;
    if (resp_valid !== 1'b0) begin errors++; $display("FAIL posted_hit_noresp got %b want 0", resp_valid); end
    // Group 1 in dstaddr[27:24] misses.
    req_valid = 1'b1;
    req_dst   = 64'h0000_0000_0100_0010;
    #1;
    checks++;
    if (reg_write !== 1'b0) begin errors++; $display("FAIL posted_miss_strobe got %b want 0", reg_write); end
    tick();
    idle_req();
    #1;
    checks++;
    if (resp_valid !== 1'b0) begin errors++; $display("FAIL posted_miss_noresp got %b want 0", resp_valid); end
    req_valid = 1'b1;
    req_cmd   = mk_cmd(OP_READ, 3'd3, 8'd0, USER);
    #1;
    checks++;
    if (reg_read !== 1'b0) begin errors++; $display("FAIL read_miss_strobe got %b want 0", reg_read); end
    tick();
    idle_req();
    #1;
    checks++;
    if (resp_valid !== 1'b1 || resp_cmd !== mk_cmd(OP_RRESP, 3'd3, 8'd0, 2'b11)) begin
      errors++; $display("FAIL read_miss_resp got v=%b cmd=%h want cmd=%h", resp_valid, resp_cmd,
                         mk_cmd(OP_RRESP, 3'd3, 8'd0, 2'b11));
    end
    tick();
  endtask

  task automatic test_no_fit();
    resp_ready = 1'b1;
    req_valid  = 1'b1;
    req_cmd    = mk_cmd(OP_READ, 3'd3, 8'd1, USER);
    req_dst    = 64'h0000_0000_0000_0100;
    #1;
    checks++;
    if (reg_read !== 1'b0) begin errors++; $display("FAIL nofit_strobe got %b want 0", reg_read); end
    tick();
    idle_req();
    #1;
    checks++;
    if (resp_valid !== 1'b1 || resp_cmd !== mk_cmd(OP_RRESP, 3'd3, 8'd1, 2'b10) || resp_data !== '0) begin
      errors++; $display("FAIL nofit_resp got v=%b cmd=%h want cmd=%h", resp_valid, resp_cmd,
                         mk_cmd(OP_RRESP, 3'd3, 8'd1, 2'b10));
    end
    tick();
  endtask

  task automatic test_atomic();
    resp_ready = 1'b1;
    reg_rddata = 64'd5;
    req_valid  = 1'b1;
    req_cmd    = mk_cmd(OP_ATOMIC, 3'd3, 8'h00, USER);
    req_dst    = 64'h0000_0000_0000_0200;
    req_data   = DW'(64'd3);
    #1;
`ifdef UMI_REGIF_ATOMIC_EN
    checks++;
    if (reg_read !== 1'b1 || reg_write !== 1'b1 || reg_wrdata !== 64'd8) begin
      errors++; $display("FAIL atomic_add got r=%b w=%b wd=%h want 1 1 8", reg_read, reg_write, reg_wrdata);
    end
    tick();
    idle_req();
    #1;
    checks++;
    if (resp_cmd !== mk_cmd(OP_RRESP, 3'd3, 8'h00, 2'b00) || resp_data !== {4{64'd5}}) begin
      errors++; $display("FAIL atomic_add_resp got cmd=%h data=%h", resp_cmd, resp_data);
    end
    tick();
    // Signed max: -1 vs 2 gives 2; unsigned max gives -1.
    reg_rddata = 64'hFFFF_FFFF_FFFF_FFFF;
    req_valid  = 1'b1;
    req_cmd    = mk_cmd(OP_ATOMIC, 3'd3, 8'h04, USER);
    req_data   = DW'(64'd2);
    #1;
    checks++;
    if (reg_wrdata !== 64'd2) begin errors++; $display("FAIL atomic_max got %h want 2", reg_wrdata); end
    req_cmd = mk_cmd(OP_ATOMIC, 3'd3, 8'h06, USER);
    #1;
    checks++;
    if (reg_wrdata !== 64'hFFFF_FFFF_FFFF_FFFF) begin
      errors++; $display("FAIL atomic_maxu got %h want ffffffffffffffff", reg_wrdata);
    end
    tick();
    idle_req();
    tick();
`else
    checks++;
    if (reg_read !== 1'b0 || reg_write !== 1'b0 || reg_wrdata !== 64'd3) begin
      errors++; $display("FAIL atomic_off got r=%b w=%b wd=%h want 0 0 3", reg_read, reg_write, reg_wrdata);
    end
    tick();
    idle_req();
    #1;
    checks++;
    if (resp_valid !== 1'b1 || resp_cmd !== mk_cmd(OP_RRESP, 3'd3, 8'h00, 2'b10)) begin
      errors++; $display("FAIL atomic_off_resp got v=%b cmd=%h want %h", resp_valid, resp_cmd,
                         mk_cmd(OP_RRESP, 3'd3, 8'h00, 2'b10));
    end
    tick();
`endif
  endtask

  task automatic test_reset_mid();
    resp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      req_valid = 1'b1;
      req_cmd   = mk_cmd(OP_READ, 3'd3, 8'd0, USER);
      req_dst   = 64'h300 + 64'(i * 8);
      tick();
    end
    idle_req();
    #1;
    checks++;
    if (resp_valid !== 1'b1) begin errors++; $display("FAIL midrst_queued got %b want 1", resp_valid); end
    nreset = 1'b0;
    #1;
    checks++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
      errors++; $display("FAIL midrst_clear got v=%b rdy=%b want 0 1", resp_valid, req_ready);
    end
    @(negedge clk);
    nreset     = 1'b1;
    resp_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (resp_valid !== 1'b0) begin errors++; $display("FAIL midrst_stale_%0d got %b want 0", i, resp_valid); end
    end
  endtask

  initial begin
    test_reset();
    test_read_hit();
    test_back_to_back();
    test_posted_and_miss();
    test_no_fit();
    test_atomic();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
